// File: rtl/xdrop_extend_ctrl.sv
// Ungapped X-drop seed extension controller.
// Streams one query/subject base pair per cycle from two synchronous-read
// memories into an external comparator, keeps a running signed score and the
// best score/length seen, and stops on X-drop, length limit or an illegal
// comparator code.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; results from the last run are held
// S_ISSUE | first read of both memories at the latched start addresses
// S_SCORE | one base scored per cycle; next read issued unless stopping
// S_DONE  | one-cycle done pulse, results valid
module xdrop_extend_ctrl #(
    parameter int QADDR_W  = 16,
    parameter int SADDR_W  = 20,
    parameter int LEN_W    = 12,
    parameter int SCORE_W  = 16,
    parameter int MATCH    = 1,
    parameter int MISMATCH = 3,
    parameter int XDROP    = 20
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [QADDR_W-1:0] q_start_i,
    input  logic [SADDR_W-1:0] s_start_i,
    input  logic [LEN_W-1:0]   max_len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               q_rd_en_o,
    output logic [QADDR_W-1:0] q_addr_o,
    input  logic [2:0]         q_data_i,
    output logic               s_rd_en_o,
    output logic [SADDR_W-1:0] s_addr_o,
    input  logic [1:0]         s_data_i,
    output logic [2:0]         cmp_q_o,
    output logic [1:0]         cmp_s_o,
    input  logic [2:0]         cmp_result_i,
    output logic [SCORE_W-1:0] best_score_o,
    output logic [LEN_W-1:0]   best_len_o,
    output logic [1:0]         stop_reason_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SCORE, S_DONE} state_t;

    // Two guard bits keep score arithmetic and the X-drop difference exact.
    localparam int EXT_W = SCORE_W + 2;
    typedef logic signed [EXT_W-1:0] ext_t;

    localparam logic [1:0] STOP_NONE    = 2'd0;
    localparam logic [1:0] STOP_XDROP   = 2'd1;
    localparam logic [1:0] STOP_LEN     = 2'd2;
    localparam logic [1:0] STOP_ILLEGAL = 2'd3;

    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam ext_t SCORE_MIN_EXT = {2'b11, SCORE_MIN};
    localparam ext_t MATCH_EXT     = ext_t'(MATCH);
    localparam ext_t MISMATCH_EXT  = ext_t'(MISMATCH);
    localparam ext_t XDROP_EXT     = ext_t'(XDROP);

    state_t                     state_q, state_d;
    logic [QADDR_W-1:0]         q_addr_q;
    logic [SADDR_W-1:0]         s_addr_q;
    logic [LEN_W-1:0]           max_len_q;
    logic [LEN_W-1:0]           count_q;
    logic signed [SCORE_W-1:0]  score_q;
    logic signed [SCORE_W-1:0]  best_score_q;
    logic [LEN_W-1:0]           best_len_q;
    logic [1:0]                 stop_q;

    logic                       cmp_legal;
    ext_t                       score_ext;
    ext_t                       step_ext;
    ext_t                       drop_ext;
    logic signed [SCORE_W-1:0]  score_new;
    logic signed [SCORE_W-1:0]  best_new;
    logic                       new_best;
    logic [LEN_W-1:0]           count_new;
    logic [1:0]                 stop_new;
    logic                       term;

    // Score the current base pair; termination is judged on the updated values.
    always_comb begin
        score_ext = {{2{score_q[SCORE_W-1]}}, score_q};
        step_ext  = score_ext;
        cmp_legal = 1'b1;
        case (cmp_result_i)
            3'b001:  step_ext = score_ext + MATCH_EXT;
            3'b010:  step_ext = score_ext - MISMATCH_EXT;
            3'b100:  step_ext = score_ext;
            default: cmp_legal = 1'b0;
        endcase
        if (step_ext < SCORE_MIN_EXT) begin
            score_new = SCORE_MIN;
        end else begin
            score_new = step_ext[SCORE_W-1:0];
        end
        count_new = count_q + 1'b1;
        new_best  = cmp_legal && (score_new > best_score_q);
        best_new  = new_best ? score_new : best_score_q;
        drop_ext  = {{2{best_new[SCORE_W-1]}}, best_new} - {{2{score_new[SCORE_W-1]}}, score_new};
        stop_new  = STOP_NONE;
        if (!cmp_legal) begin
            stop_new = STOP_ILLEGAL;
        end else if (drop_ext > XDROP_EXT) begin
            stop_new = STOP_XDROP;
        end else if (count_new == max_len_q) begin
            stop_new = STOP_LEN;
        end
        term = (stop_new != STOP_NONE);
    end

    // Next state and read strobes; reads are only issued when another base is needed.
    always_comb begin
        state_d   = state_q;
        q_rd_en_o = 1'b0;
        s_rd_en_o = 1'b0;
        q_addr_o  = q_addr_q;
        s_addr_o  = s_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (max_len_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                q_rd_en_o = 1'b1;
                s_rd_en_o = 1'b1;
                state_d   = S_SCORE;
            end
            S_SCORE: begin
                if (term) begin
                    state_d = S_DONE;
                end else begin
                    q_rd_en_o = 1'b1;
                    s_rd_en_o = 1'b1;
                    q_addr_o  = q_addr_q + 1'b1;
                    s_addr_o  = s_addr_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign cmp_q_o       = q_data_i;
    assign cmp_s_o       = s_data_i;
    assign best_score_o  = best_score_q;
    assign best_len_o    = best_len_q;
    assign stop_reason_o = stop_q;

    // State register plus run bookkeeping; acceptance clears the previous results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            q_addr_q     <= '0;
            s_addr_q     <= '0;
            max_len_q    <= '0;
            count_q      <= '0;
            score_q      <= '0;
            best_score_q <= '0;
            best_len_q   <= '0;
            stop_q       <= STOP_NONE;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        count_q      <= '0;
                        score_q      <= '0;
                        best_score_q <= '0;
                        best_len_q   <= '0;
                        if (max_len_i == '0) begin
                            stop_q <= STOP_LEN;
                        end else begin
                            stop_q    <= STOP_NONE;
                            q_addr_q  <= q_start_i;
                            s_addr_q  <= s_start_i;
                            max_len_q <= max_len_i;
                        end
                    end
                end
                S_SCORE: begin
                    if (cmp_legal) begin
                        score_q <= score_new;
                        count_q <= count_new;
                        if (new_best) begin
                            best_score_q <= score_new;
                            best_len_q   <= count_new;
                        end
                    end
                    stop_q <= stop_new;
                    if (!term) begin
                        q_addr_q <= q_addr_o;
                        s_addr_q <= s_addr_o;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
